dds_core: RTL and testbench



---
 rtl/dds_core.sv | 148 ++++++++++++++
 tb/tb_dds_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_core.sv
// Direct digital synthesizer: phase accumulator, quarter-wave sine ROM with
// quadrant folding, offset-binary sample output and first-order sigma-delta bitstream.
module dds_core #(
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_ADDR    = 8,
  parameter int AMP_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [PHASE_WIDTH-1:0] code,
  input  logic                   code_valid,
  input  logic                   sync,
  output logic [AMP_WIDTH-1:0]   sample,
  output logic                   sq_out,
  output logic                   out
);

  localparam int ROM_DEPTH = 2 ** LUT_ADDR;
  localparam int MAG_W     = AMP_WIDTH - 1;
  localparam int ROM_BITS  = ROM_DEPTH * MAG_W;
  localparam int AMP_MAX   = (2 ** (AMP_WIDTH - 1)) - 1;
  localparam logic [AMP_WIDTH-1:0] MID    = {1'b1, {(AMP_WIDTH-1){1'b0}}};
  localparam logic [AMP_WIDTH-1:0] MID_M1 = {1'b0, {(AMP_WIDTH-1){1'b1}}};
  // pi scaled by 2^60
  localparam logic [127:0] PI_Q = {64'h0, 64'h3243F6A8885A308D};

  // Fixed-point Taylor series of sin(pi/2*(k+0.5)/ROM_DEPTH), Q60, rounded to nearest.
  function automatic logic [ROM_BITS-1:0] gen_rom();
    logic [ROM_BITS-1:0] rom;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] val;
    rom = '0;
    for (int k = 0; k < ROM_DEPTH; k++) begin
      x    = (PI_Q * 128'(2 * k + 1)) >> (LUT_ADDR + 2);
      x2   = (x * x) >> 60;
      term = x;
      sum  = x;
      for (int n = 1; n < 16; n++) begin
        term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
        if (n[0]) begin
          sum = sum - term;
        end else begin
          sum = sum + term;
        end
      end
      val = (sum * 128'(AMP_MAX) + (128'd1 << 59)) >> 60;
      rom[k*MAG_W +: MAG_W] = MAG_W'(val);
    end
    return rom;
  endfunction

  localparam logic [ROM_BITS-1:0] ROM_FLAT = gen_rom();

  logic [MAG_W-1:0] rom_s [ROM_DEPTH];
  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    assign rom_s[k] = ROM_FLAT[k*MAG_W +: MAG_W];
  end

  logic [PHASE_WIDTH-1:0] tw_q, tw_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [LUT_ADDR-1:0]    idx_q, idx_d;
  logic                   s1_sign_q, s1_sign_d;
  logic [MAG_W-1:0]       mag_q, mag_d;
  logic                   s2_sign_q, s2_sign_d;
  logic [AMP_WIDTH-1:0]   sample_q, sample_d;
  logic                   sq_q, sq_d;
  logic [AMP_WIDTH-1:0]   acc_q, acc_d;
  logic                   out_q, out_d;
  logic [AMP_WIDTH:0]     sd_sum_s;
  logic [LUT_ADDR-1:0]    raw_idx_s;

  // Next-state for accumulator, fold, ROM, sign apply and modulator
  always_comb begin
    tw_d      = tw_q;
    phase_d   = phase_q;
    raw_idx_s = phase_q[PHASE_WIDTH-3 -: LUT_ADDR];
    idx_d     = raw_idx_s;
    sd_sum_s  = {1'b0, acc_q} + {1'b0, sample_q};

    if (code_valid) begin
      tw_d = code;
    end else begin
      tw_d = tw_q;
    end

    // sync wins over accumulation; a simultaneous load still takes effect above
    if (sync) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + tw_q;
    end

    if (phase_q[PHASE_WIDTH-2]) begin
      idx_d = ~raw_idx_s;
    end else begin
      idx_d = raw_idx_s;
    end
    s1_sign_d = phase_q[PHASE_WIDTH-1];

    mag_d     = rom_s[idx_q];
    s2_sign_d = s1_sign_q;

    if (s2_sign_q) begin
      sample_d = MID_M1 - {1'b0, mag_q};
    end else begin
      sample_d = MID + {1'b0, mag_q};
    end
    sq_d = s2_sign_q;

    acc_d = sd_sum_s[AMP_WIDTH-1:0];
    out_d = sd_sum_s[AMP_WIDTH];
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tw_q      <= '0;
      phase_q   <= '0;
      idx_q     <= '0;
      s1_sign_q <= 1'b0;
      mag_q     <= '0;
      s2_sign_q <= 1'b0;
      sample_q  <= '0;
      sq_q      <= 1'b0;
      acc_q     <= '0;
      out_q     <= 1'b0;
    end else begin
      tw_q      <= tw_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      s1_sign_q <= s1_sign_d;
      mag_q     <= mag_d;
      s2_sign_q <= s2_sign_d;
      sample_q  <= sample_d;
      sq_q      <= sq_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
    end
  end

  assign sample = sample_q;
  assign sq_out = sq_q;
  assign out    = out_q;

endmodule

// File: tb/tb_dds_core.sv
// Directed testbench for dds_core with hand-computed expected samples.
module tb_dds_core;

  logic        clk;
  logic        nreset;
  logic [31:0] code;
  logic        code_valid;
  logic        sync;
  logic [9:0]  sample;
  logic        sq_out;
  logic        out;

  int pass_cnt;
  int total_cnt;

  dds_core dut (
    .clk        (clk),
    .nreset     (nreset),
    .code       (code),
    .code_valid (code_valid),
    .sync       (sync),
    .sample     (sample),
    .sq_out     (sq_out),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset     = 1'b0;
    code_valid = 1'b0;
    sync       = 1'b0;
    code       = 32'h0;
    tick();
    nreset = 1'b1;
    #1;
  endtask

  task automatic check_sample(input string name, input logic [9:0] exp);
    total_cnt++;
    if (sample !== exp) $display("FAIL %s: sample=%0d expected=%0d", name, sample, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    #2;
    total_cnt++;
    if ({sample, sq_out, out} !== 12'h000)
      $display("FAIL reset_outputs: sample=%0d sq=%b out=%b expected 0 0 0", sample, sq_out, out);
    else pass_cnt++;
    do_reset();
    tick(); tick(); tick();
    check_sample("reset_release_sample", 10'd514);
  endtask

  task automatic test_quadrant_walk();
    logic [9:0] exp_s [4];
    logic       exp_q [4];
    exp_s = '{10'd514, 10'd1023, 10'd509, 10'd0};
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    code = 32'h40000000; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_sample("quad_sample", exp_s[i%4]);
      total_cnt++;
      if (sq_out !== exp_q[i%4]) $display("FAIL quad_sq: step %0d sq=%b expected=%b", i, sq_out, exp_q[i%4]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sigma_delta();
    int ones;
    do_reset();
    tick(); tick(); tick();
    check_sample("sd_sample_const", 10'd514);
    tick();
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (out === 1'b1) ones++;
    end
    total_cnt++;
    if (ones !== 514) $display("FAIL sd_density: ones=%0d expected=514", ones);
    else pass_cnt++;
    check_sample("sd_sample_end", 10'd514);
  endtask

  task automatic test_wrap();
    logic [31:0] model;
    do_reset();
    code = 32'h80000001; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    model = 32'h0;
    total_cnt++;
    if (dut.phase_q !== model) $display("FAIL wrap_phase0: phase=%h expected=%h", dut.phase_q, model);
    else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      model = model + 32'h80000001;
      total_cnt++;
      if (dut.phase_q !== model) $display("FAIL wrap_phase: step %0d phase=%h expected=%h", k, dut.phase_q, model);
      else pass_cnt++;
    end
  endtask

  task automatic test_sync_load();
    logic [9:0] exp_s [4];
    exp_s = '{10'd514, 10'd1023, 10'd509, 10'd0};
    sync = 1'b1; code_valid = 1'b1; code = 32'h40000000;
    tick();
    sync = 1'b0; code_valid = 1'b0;
    total_cnt++;
    if (dut.phase_q !== 32'h0 || dut.tw_q !== 32'h40000000)
      $display("FAIL sync_load_regs: phase=%h tw=%h expected 00000000 40000000", dut.phase_q, dut.tw_q);
    else pass_cnt++;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_sample("sync_sample", exp_s[i]);
    end
  endtask

  task automatic test_reset_midstream();
    int toggles;
    logic prev;
    do_reset();
    code = 32'h12345678; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    toggles = 0;
    prev = out;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out !== prev) toggles++;
      prev = out;
    end
    total_cnt++;
    if (toggles == 0) $display("FAIL mid_toggle: toggles=%0d expected nonzero", toggles);
    else pass_cnt++;
    #1;
    nreset = 1'b0;
    #1;
    total_cnt++;
    if ({sample, sq_out, out} !== 12'h000)
      $display("FAIL mid_reset_async: sample=%0d sq=%b out=%b expected 0 0 0", sample, sq_out, out);
    else pass_cnt++;
    #1;
    nreset = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if (dut.tw_q !== 32'h0) $display("FAIL mid_tw_cleared: tw=%h expected=00000000", dut.tw_q);
    else pass_cnt++;
    check_sample("mid_sample_a", 10'd514);
    for (int i = 0; i < 5; i++) tick();
    check_sample("mid_sample_b", 10'd514);
  endtask

  task automatic test_freq_change();
    logic [9:0] exp_s [6];
    exp_s = '{10'd1023, 10'd509, 10'd149, 10'd0, 10'd151, 10'd514};
    do_reset();
    code = 32'h40000000; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    code = 32'h20000000; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    total_cnt++;
    if (dut.phase_q !== 32'h80000000 || dut.tw_q !== 32'h20000000)
      $display("FAIL fc_edge_n: phase=%h tw=%h expected 80000000 20000000", dut.phase_q, dut.tw_q);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dut.phase_q !== 32'hA0000000) $display("FAIL fc_phase_cont: phase=%h expected=A0000000", dut.phase_q);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_sample("fc_sample", exp_s[i]);
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    nreset     = 1'b0;
    code       = 32'h0;
    code_valid = 1'b0;
    sync       = 1'b0;
    tick();
    test_reset();
    test_quadrant_walk();
    test_sigma_delta();
    test_wrap();
    test_sync_load();
    test_reset_midstream();
    test_freq_change();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
